wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 35 +++
 rtl/load_ext.sv | 38 +++
 rtl/wb_stage.sv | 78 +++++++
 tb/tb_wb_stage.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared CPU definitions for the writeback stage: result-select and load-type
// encodings, the W pipeline register layout and small extension helpers.
package wb_stage_pkg;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_PC8 = 2'd2;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_H  = 3'd1;
    localparam logic [2:0] LD_HU = 3'd2;
    localparam logic [2:0] LD_B  = 3'd3;
    localparam logic [2:0] LD_BU = 3'd4;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [2:0]  ldtype;
        logic [1:0]  off;
    } w_reg_t;

    function automatic logic [31:0] ext16(input logic [15:0] half, input logic sgn);
        return {{16{sgn & half[15]}}, half};
    endfunction

    function automatic logic [31:0] ext8(input logic [7:0] bval, input logic sgn);
        return {{24{sgn & bval[7]}}, bval};
    endfunction

endpackage

// File: rtl/load_ext.sv
// Load data extraction: picks the addressed halfword/byte out of an aligned
// memory word and sign- or zero-extends it to 32 bits.
module load_ext
    import wb_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  ldtype,
    output logic [31:0] value
);

    logic [15:0] half;
    logic [7:0]  bsel;

    always_comb begin
        // Halfword selection ignores off[0]; misaligned halves are not split.
        half = off[1] ? word[31:16] : word[15:0];
        unique case (off)
            2'd0:    bsel = word[7:0];
            2'd1:    bsel = word[15:8];
            2'd2:    bsel = word[23:16];
            default: bsel = word[31:24];
        endcase
    end

    always_comb begin
        value = word;
        case (ldtype)
            LD_W:    value = word;
            LD_H:    value = ext16(half, 1'b1);
            LD_HU:   value = ext16(half, 1'b0);
            LD_B:    value = ext8(bsel, 1'b1);
            LD_BU:   value = ext8(bsel, 1'b0);
            default: value = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: registers the M-stage slot, forms the GPR write and counts
// retired instructions.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m_valid,
    input  logic [31:0]      m_pc,
    input  logic [4:0]       m_rd,
    input  logic             m_regwrite,
    input  logic [1:0]       m_sel,
    input  logic [31:0]      m_alu,
    input  logic [31:0]      m_mem,
    input  logic [2:0]       m_ldtype,
    input  logic [1:0]       m_off,
    input  logic             flush,
    output logic [4:0]       grf_waddr,
    output logic [31:0]      grf_wdata,
    output logic             grf_wen,
    output logic [31:0]      grf_pc,
    output logic [CNT_W-1:0] retired
);

    w_reg_t           w_d, w_q;
    logic [CNT_W-1:0] retired_q;
    logic [31:0]      load_val;

    always_comb begin
        w_d          = '0;
        // A flushed slot enters W as a bubble that can never write.
        w_d.valid    = m_valid & ~flush;
        w_d.regwrite = m_regwrite & ~flush;
        w_d.rd       = m_rd;
        w_d.sel      = m_sel;
        w_d.pc       = m_pc;
        w_d.alu      = m_alu;
        w_d.mem      = m_mem;
        w_d.ldtype   = m_ldtype;
        w_d.off      = m_off;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q       <= '0;
            retired_q <= '0;
        end else begin
            w_q <= w_d;
            if (w_q.valid) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    load_ext u_load_ext (
        .word   (w_q.mem),
        .off    (w_q.off),
        .ldtype (w_q.ldtype),
        .value  (load_val)
    );

    always_comb begin
        grf_wdata = w_q.alu;
        case (w_q.sel)
            SEL_MEM: grf_wdata = load_val;
            SEL_PC8: grf_wdata = w_q.pc + 32'd8;
            default: grf_wdata = w_q.alu;
        endcase
    end

    assign grf_wen   = w_q.valid & w_q.regwrite & (w_q.rd != 5'd0);
    assign grf_waddr = w_q.rd;
    assign grf_pc    = w_q.pc;
    assign retired   = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected writes are queued as slots are driven
// and popped when the slot reaches W; a CNT_W=4 copy checks counter wrap.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [4:0]  m_rd;
    logic        m_regwrite;
    logic [1:0]  m_sel;
    logic [31:0] m_alu;
    logic [31:0] m_mem;
    logic [2:0]  m_ldtype;
    logic [1:0]  m_off;
    logic        flush;

    logic [4:0]  grf_waddr, grf_waddr4;
    logic [31:0] grf_wdata, grf_wdata4;
    logic        grf_wen, grf_wen4;
    logic [31:0] grf_pc, grf_pc4;
    logic [31:0] retired;
    logic [3:0]  retired4;

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_ret;
    logic        model_vw;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_pc(m_pc), .m_rd(m_rd),
        .m_regwrite(m_regwrite), .m_sel(m_sel), .m_alu(m_alu), .m_mem(m_mem),
        .m_ldtype(m_ldtype), .m_off(m_off), .flush(flush),
        .grf_waddr(grf_waddr), .grf_wdata(grf_wdata), .grf_wen(grf_wen),
        .grf_pc(grf_pc), .retired(retired)
    );

    wb_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_pc(m_pc), .m_rd(m_rd),
        .m_regwrite(m_regwrite), .m_sel(m_sel), .m_alu(m_alu), .m_mem(m_mem),
        .m_ldtype(m_ldtype), .m_off(m_off), .flush(flush),
        .grf_waddr(grf_waddr4), .grf_wdata(grf_wdata4), .grf_wen(grf_wen4),
        .grf_pc(grf_pc4), .retired(retired4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [1:0] sel, input logic [31:0] pc,
                                             input logic [31:0] alu, input logic [31:0] mem,
                                             input logic [2:0] ld, input logic [1:0] off);
        logic [31:0] sh;
        logic [15:0] hw;
        sh = mem >> {off, 3'b000};
        hw = off[1] ? mem[31:16] : mem[15:0];
        if (sel == 2'd2) return pc + 32'd8;
        if (sel != 2'd1) return alu;
        case (ld)
            3'd1:    return {{16{hw[15]}}, hw};
            3'd2:    return {16'h0000, hw};
            3'd3:    return {{24{sh[7]}}, sh[7:0]};
            3'd4:    return {24'h000000, sh[7:0]};
            default: return mem;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wen"}, {31'd0, grf_wen}, 32'd0);
        check({tag, "_waddr"}, {27'd0, grf_waddr}, 32'd0);
        check({tag, "_wdata"}, grf_wdata, 32'd0);
        check({tag, "_pc"}, grf_pc, 32'd0);
        check({tag, "_retired"}, retired, 32'd0);
        check({tag, "_retired4"}, {28'd0, retired4}, 32'd0);
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                        input logic rw, input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [2:0] ld, input logic [1:0] off,
                        input logic fl);
        exp_t e;
        m_valid = v; m_pc = pc; m_rd = rd; m_regwrite = rw; m_sel = sel;
        m_alu = alu; m_mem = mem; m_ldtype = ld; m_off = off; flush = fl;
        e.wen   = v && !fl && rw && (rd != 5'd0);
        e.waddr = rd;
        e.wdata = exp_data(sel, pc, alu, mem, ld, off);
        e.pc    = pc;
        sb.push_back(e);
        @(posedge clk);
        model_ret = model_ret + {31'd0, model_vw};
        model_vw  = v && !fl;
        #1;
        e = sb.pop_front();
        check("wen", {31'd0, grf_wen}, {31'd0, e.wen});
        check("waddr", {27'd0, grf_waddr}, {27'd0, e.waddr});
        check("wdata", grf_wdata, e.wdata);
        check("pc", grf_pc, e.pc);
        check("wen4", {31'd0, grf_wen4}, {31'd0, e.wen});
        check("retired", retired, model_ret);
        check("retired4", {28'd0, retired4}, model_ret & 32'h0000_000F);
    endtask

    initial begin
        // Reset held with a live-looking slot on the inputs.
        reset = 1'b1;
        m_valid = 1'b1; m_pc = 32'h0000_0100; m_rd = 5'd3; m_regwrite = 1'b1;
        m_sel = 2'd0; m_alu = 32'hDEAD_BEEF; m_mem = 32'h0; m_ldtype = 3'd0;
        m_off = 2'd0; flush = 1'b0;
        #2;
        check_reset_outputs("rst_async");
        @(posedge clk); #1;
        check_reset_outputs("rst_edge");
        @(negedge clk);
        reset = 1'b0;
        model_ret = 32'd0;
        model_vw = 1'b0;

        // ALU path, then load extraction over one memory word.
        step(1, 32'h0000_1000, 5'd8, 1, 2'd0, 32'h1234_5678, 32'h0, 3'd0, 2'd0, 0);
        step(1, 32'h0000_1004, 5'd9, 1, 2'd1, 32'h0, 32'h80FF_7F01, 3'd3, 2'd2, 0);
        step(1, 32'h0000_1008, 5'd10, 1, 2'd1, 32'h0, 32'h80FF_7F01, 3'd4, 2'd3, 0);
        step(1, 32'h0000_100C, 5'd11, 1, 2'd1, 32'h0, 32'h80FF_7F01, 3'd1, 2'd0, 0);
        step(1, 32'h0000_1010, 5'd12, 1, 2'd1, 32'h0, 32'h80FF_7F01, 3'd1, 2'd2, 0);
        step(1, 32'h0000_1014, 5'd13, 1, 2'd1, 32'h0, 32'h80FF_7F01, 3'd2, 2'd3, 0);
        step(1, 32'h0000_1018, 5'd14, 1, 2'd1, 32'h0, 32'h80FF_7F01, 3'd0, 2'd3, 0);
        step(1, 32'h0000_101C, 5'd15, 1, 2'd1, 32'h0, 32'h80FF_7F01, 3'd3, 2'd1, 0);
        step(1, 32'h0000_1020, 5'd16, 1, 2'd1, 32'h0, 32'h80FF_7F01, 3'd7, 2'd1, 0);
        // PC+8 including wraparound, reserved select behaving as ALU.
        step(1, 32'h0000_3000, 5'd31, 1, 2'd2, 32'h0, 32'h0, 3'd0, 2'd0, 0);
        step(1, 32'hFFFF_FFFC, 5'd1, 1, 2'd2, 32'h0, 32'h0, 3'd0, 2'd0, 0);
        step(1, 32'h0000_1028, 5'd2, 1, 2'd3, 32'hCAFE_0001, 32'h1111_1111, 3'd0, 2'd0, 0);
        // rd=0, regwrite=0, flushed slot, plain bubble.
        step(1, 32'h0000_102C, 5'd0, 1, 2'd0, 32'h5555_AAAA, 32'h0, 3'd0, 2'd0, 0);
        step(1, 32'h0000_1030, 5'd7, 0, 2'd0, 32'h0000_0077, 32'h0, 3'd0, 2'd0, 0);
        step(1, 32'h0000_1034, 5'd5, 1, 2'd0, 32'h0000_0055, 32'h0, 3'd0, 2'd0, 1);
        step(0, 32'h0000_1038, 5'd6, 1, 2'd0, 32'h0000_0066, 32'h0, 3'd0, 2'd0, 0);
        step(1, 32'h0000_103C, 5'd20, 1, 2'd0, 32'hA5A5_A5A5, 32'h0, 3'd0, 2'd0, 0);

        // Asynchronous reset mid-cycle while W holds a valid write.
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        sb.delete();
        m_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_ret = 32'd0;
        model_vw = 1'b0;
        step(0, 32'h0000_2000, 5'd4, 1, 2'd0, 32'h0000_0044, 32'h0, 3'd0, 2'd0, 0);
        step(1, 32'h0000_2004, 5'd4, 1, 2'd0, 32'h0000_0045, 32'h0, 3'd0, 2'd0, 0);

        // Fresh counters, then 17 valid slots back-to-back and a bubble.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        model_ret = 32'd0;
        model_vw = 1'b0;
        for (int i = 0; i < 17; i++) begin
            step(1, 32'h0000_4000 + 32'(i) * 4, 5'(i + 1), 1, 2'd0, 32'(i), 32'h0, 3'd0,
                 2'd0, 0);
        end
        step(0, 32'h0000_5000, 5'd0, 0, 2'd0, 32'h0, 32'h0, 3'd0, 2'd0, 0);
        check("wrap4", {28'd0, retired4}, 32'd1);
        check("count17", retired, 32'd17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
